// File: rtl/scratch_stack_ctrl.sv
// Scratch stack sequencer: TOS/NOS registers with spill/refill to a registered-output RAM.
// Optional SWAP command is enabled by defining SCRATCH_STACK_SWAP_EN.
module scratch_stack_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              cmd_ready,
    output logic [DATA_W-1:0] tos,
    output logic [DATA_W-1:0] nos,
    output logic [ADDR_W+1:0] depth,
    output logic              err_overflow,
    output logic              err_underflow,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wen,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD_WAIT = 2'd2, RD_CAP = 2'd3} state_t;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_REPL = 2'b10;

    localparam logic [ADDR_W+1:0] DEPTH_ONE  = (ADDR_W+2)'(1);
    localparam logic [ADDR_W+1:0] DEPTH_TWO  = (ADDR_W+2)'(2);
    localparam logic [ADDR_W+1:0] DEPTH_FULL = (ADDR_W+2)'((1 << ADDR_W) + 2);
    localparam logic [ADDR_W:0]   SP_ONE     = (ADDR_W+1)'(1);

    state_t              state;
    logic [DATA_W-1:0]   tos_q;
    logic [DATA_W-1:0]   nos_q;
    logic [ADDR_W+1:0]   depth_q;
    logic [ADDR_W:0]     sp_q;

    // Handshake: a command transfers on any rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, and rejected commands are still consumed.
    assign cmd_ready = (state == IDLE);
    assign tos       = tos_q;
    assign nos       = nos_q;
    assign depth     = depth_q;
    assign fsm_state = state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            tos_q         <= '0;
            nos_q         <= '0;
            depth_q       <= '0;
            sp_q          <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            ram_addr      <= '0;
            ram_wdata     <= '0;
            ram_wen       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_PUSH: begin
                                if (depth_q == DEPTH_FULL) begin
                                    err_overflow <= 1'b1;
                                end else begin
                                    tos_q   <= cmd_data;
                                    nos_q   <= tos_q;
                                    depth_q <= depth_q + DEPTH_ONE;
                                    if (depth_q >= DEPTH_TWO) begin
                                        ram_addr  <= sp_q[ADDR_W-1:0];
                                        ram_wdata <= nos_q;
                                        ram_wen   <= 1'b1;
                                        sp_q      <= sp_q + SP_ONE;
                                        state     <= WR;
                                    end
                                end
                            end
                            OP_POP: begin
                                if (depth_q == '0) begin
                                    err_underflow <= 1'b1;
                                end else begin
                                    tos_q   <= nos_q;
                                    depth_q <= depth_q - DEPTH_ONE;
                                    if (sp_q != '0) begin
                                        ram_addr <= ADDR_W'(sp_q - SP_ONE);
                                        sp_q     <= sp_q - SP_ONE;
                                        state    <= RD_WAIT;
                                    end
                                end
                            end
                            OP_REPL: begin
                                if (depth_q < DEPTH_TWO) begin
                                    err_underflow <= 1'b1;
                                end else begin
                                    tos_q   <= cmd_data;
                                    depth_q <= depth_q - DEPTH_ONE;
                                    if (sp_q != '0) begin
                                        ram_addr <= ADDR_W'(sp_q - SP_ONE);
                                        sp_q     <= sp_q - SP_ONE;
                                        state    <= RD_WAIT;
                                    end
                                end
                            end
                            default: begin
`ifdef SCRATCH_STACK_SWAP_EN
                                if (depth_q < DEPTH_TWO) begin
                                    err_underflow <= 1'b1;
                                end else begin
                                    tos_q <= nos_q;
                                    nos_q <= tos_q;
                                end
`else
                                // Op 11 is a consumed no-op in this build.
                                state <= IDLE;
`endif
                            end
                        endcase
                    end
                end
                WR: begin
                    ram_wen <= 1'b0;
                    state   <= IDLE;
                end
                RD_WAIT: state <= RD_CAP;
                RD_CAP: begin
                    nos_q <= ram_rdata;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scratch_stack_ctrl.sv
// Directed bench for scratch_stack_ctrl with a registered-output RAM model.
module tb_scratch_stack_ctrl;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_REPL = 2'b10;
    localparam logic [1:0] OP_SWAP = 2'b11;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        cmd_ready;
    logic [31:0] tos;
    logic [31:0] nos;
    logic [9:0]  depth;
    logic        err_overflow;
    logic        err_underflow;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_wen;
    logic [31:0] ram_rdata;
    logic [1:0]  fsm_state;

    logic [31:0] mem [256];

    int checks = 0;
    int errors = 0;

    scratch_stack_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .tos(tos), .nos(nos), .depth(depth),
        .err_overflow(err_overflow), .err_underflow(err_underflow),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wen(ram_wen), .ram_rdata(ram_rdata),
        .fsm_state(fsm_state)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (ram_wen) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        if (n >= 8) check("ready_timeout", 64'(cmd_ready), 64'd1);
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [31:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic push(input logic [31:0] data);
        wait_ready();
        do_cmd(OP_PUSH, data);
    endtask

    initial begin
        RST = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0;
        tick(); tick();
        RST = 1'b0;
        check("rst_ready", 64'(cmd_ready), 64'd1);
        check("rst_tos", 64'(tos), 64'd0);
        check("rst_nos", 64'(nos), 64'd0);
        check("rst_depth", 64'(depth), 64'd0);
        check("rst_errs", 64'({err_overflow, err_underflow}), 64'd0);
        check("rst_ram", 64'({ram_wen, ram_addr, ram_wdata}), 64'd0);
        check("rst_state", 64'(fsm_state), 64'd0);

        // Three pushes; the third spills 0x11 to address 0.
        push(32'h11);
        check("p1_tos", 64'(tos), 64'h11);
        check("p1_ready", 64'(cmd_ready), 64'd1);
        check("p1_wen", 64'(ram_wen), 64'd0);
        push(32'h22);
        check("p2_tos", 64'(tos), 64'h22);
        check("p2_nos", 64'(nos), 64'h11);
        check("p2_ready", 64'(cmd_ready), 64'd1);
        push(32'h33);
        check("p3_tos", 64'(tos), 64'h33);
        check("p3_nos", 64'(nos), 64'h22);
        check("p3_depth", 64'(depth), 64'd3);
        check("p3_ready", 64'(cmd_ready), 64'd0);
        check("p3_spill", 64'({ram_wen, ram_addr, ram_wdata}), {31'd0, 1'b1, 8'd0, 32'h11});
        tick();
        check("p3_ready_back", 64'(cmd_ready), 64'd1);
        check("p3_wen_low", 64'(ram_wen), 64'd0);

        // Pop with refill: two wait cycles, then NOS comes back from RAM.
        do_cmd(OP_POP, 32'h0);
        check("pop_tos", 64'(tos), 64'h22);
        check("pop_depth", 64'(depth), 64'd2);
        check("pop_ready0", 64'(cmd_ready), 64'd0);
        tick();
        check("pop_ready1", 64'(cmd_ready), 64'd0);
        tick();
        check("pop_ready2", 64'(cmd_ready), 64'd1);
        check("pop_nos", 64'(nos), 64'h11);
        do_cmd(OP_POP, 32'h0);
        check("pop2_tos", 64'(tos), 64'h11);
        check("pop2_depth", 64'(depth), 64'd1);
        check("pop2_ready", 64'(cmd_ready), 64'd1);
        check("pop2_wen", 64'(ram_wen), 64'd0);
        do_cmd(OP_POP, 32'h0);
        check("pop3_depth", 64'(depth), 64'd0);

        // Fill to capacity, then overflow.
        for (int i = 0; i < 258; i++) begin
            push(32'(i));
            if (i == 257) check("top_spill", 64'({ram_wen, ram_addr, ram_wdata}), {31'd0, 1'b1, 8'd255, 32'd255});
        end
        wait_ready();
        check("full_depth", 64'(depth), 64'd258);
        check("full_ovf", 64'(err_overflow), 64'd0);
        check("full_tos", 64'(tos), 64'd257);
        check("full_nos", 64'(nos), 64'd256);
        do_cmd(OP_PUSH, 32'hDEAD);
        check("ovf_flag", 64'(err_overflow), 64'd1);
        check("ovf_depth", 64'(depth), 64'd258);
        check("ovf_tos", 64'(tos), 64'd257);
        check("ovf_ready", 64'(cmd_ready), 64'd1);

        // Drain in LIFO order, then underflow.
        for (int i = 257; i >= 0; i--) begin
            wait_ready();
            check("lifo_tos", 64'(tos), 64'(i));
            do_cmd(OP_POP, 32'h0);
        end
        wait_ready();
        check("empty_depth", 64'(depth), 64'd0);
        check("empty_unf", 64'(err_underflow), 64'd0);
        do_cmd(OP_POP, 32'h0);
        check("unf_flag", 64'(err_underflow), 64'd1);
        check("unf_depth", 64'(depth), 64'd0);
        check("unf_ovf_sticky", 64'(err_overflow), 64'd1);

        // REPLACE2 with a single operand is rejected.
        RST = 1'b1; tick(); RST = 1'b0;
        push(32'h7);
        do_cmd(OP_REPL, 32'h9);
        check("r2_unf", 64'(err_underflow), 64'd1);
        check("r2_tos", 64'(tos), 64'h7);
        check("r2_depth", 64'(depth), 64'd1);

        // [1,2,3] REPLACE2 5 -> [1,5], then op 11.
        RST = 1'b1; tick(); RST = 1'b0;
        push(32'd1); push(32'd2); push(32'd3);
        wait_ready();
        do_cmd(OP_REPL, 32'd5);
        check("repl_tos", 64'(tos), 64'd5);
        check("repl_depth", 64'(depth), 64'd2);
        check("repl_ready", 64'(cmd_ready), 64'd0);
        wait_ready();
        check("repl_nos", 64'(nos), 64'd1);
        do_cmd(OP_SWAP, 32'h0);
        check("swap_ready", 64'(cmd_ready), 64'd1);
        check("swap_depth", 64'(depth), 64'd2);
        check("swap_unf", 64'(err_underflow), 64'd0);
`ifdef SCRATCH_STACK_SWAP_EN
        check("swap_tos", 64'(tos), 64'd1);
        check("swap_nos", 64'(nos), 64'd5);
        do_cmd(OP_POP, 32'h0);
        check("swap_pop_tos", 64'(tos), 64'd5);
        do_cmd(OP_SWAP, 32'h0);
        check("swap1_unf", 64'(err_underflow), 64'd1);
`else
        check("swap_tos", 64'(tos), 64'd5);
        check("swap_nos", 64'(nos), 64'd1);
        do_cmd(OP_POP, 32'h0);
        check("swap_pop_tos", 64'(tos), 64'd1);
        do_cmd(OP_SWAP, 32'h0);
        check("swap1_unf", 64'(err_underflow), 64'd0);
`endif
        check("swap1_depth", 64'(depth), 64'd1);

        // Get a sticky error set, then abort a refill with reset in RD_WAIT.
        do_cmd(OP_POP, 32'h0);
        do_cmd(OP_POP, 32'h0);
        check("pre_abort_unf", 64'(err_underflow), 64'd1);
        push(32'd1); push(32'd2); push(32'd3);
        wait_ready();
        do_cmd(OP_POP, 32'h0);
        check("abort_in_rdwait", 64'(fsm_state), 64'd2);
        RST = 1'b1; tick(); RST = 1'b0;
        check("abort_ready", 64'(cmd_ready), 64'd1);
        check("abort_depth", 64'(depth), 64'd0);
        check("abort_wen", 64'(ram_wen), 64'd0);
        check("abort_errs", 64'({err_overflow, err_underflow}), 64'd0);
        check("abort_state", 64'(fsm_state), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scratch_stack_ctrl.md
# scratch_stack_ctrl

Sequencer for the CPU's scratch (data) stack: owns the top-of-stack (TOS) and next-on-stack (NOS) registers, and spills to or refills from the 256×32 registered-output block RAM (`cellram_scratch`). It replaces the ad-hoc push/pop phase counters in the core.

The core issues one stack command per valid/ready handshake, reads TOS/NOS combinationally from this block's outputs, and gets sticky overflow/underflow flags instead of silent wrap of the RAM pointer.

## Interface
Parameters:
- `ADDR_W`, default 8: RAM address width; RAM holds 2^ADDR_W words.
- `DATA_W`, default 32: stack word width.

Ports:
- `CLK`  in  1  clock; everything is on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_op`  in  2  command: 00 PUSH, 01 POP, 10 REPLACE2 (a b => cmd_data), 11 SWAP.
- `cmd_data`  in  DATA_W  value for PUSH and REPLACE2.
- `cmd_ready`  out  1  block can accept a command this cycle.
- `tos`  out  DATA_W  top of stack; valid when `depth` ≥ 1.
- `nos`  out  DATA_W  second element; valid when `depth` ≥ 2.
- `depth`  out  ADDR_W+2  total element count, range 0..2^ADDR_W+2.
- `err_overflow`  out  1  sticky: a PUSH was rejected because the stack was full.
- `err_underflow`  out  1  sticky: a POP, REPLACE2 or SWAP was rejected for lack of operands.
- `ram_addr`  out  ADDR_W  to RAM ADDR.
- `ram_wdata`  out  DATA_W  to RAM WDATA.
- `ram_wen`  out  1  to RAM WEN.
- `ram_rdata`  in  DATA_W  from RAM RDATA; RAM registers its output one clock after sampling `ram_addr`.

## Operation
- Internal state:
  - `sp`: number of words spilled to RAM, always equal to max(depth−2, 0). The RAM top is at `sp`−1.
  - FSM states: IDLE, WR, RD_WAIT, RD_CAP.
  - `cmd_ready` = 1 only in IDLE.
- A command is accepted on a cycle with `cmd_valid` && `cmd_ready` (the accept edge). The command is evaluated against `depth` as it stands at acceptance.
- PUSH:
  - If depth = 2^ADDR_W+2, reject: `err_overflow` is set, no other state changes, FSM stays in IDLE.
  - Otherwise `tos`←`cmd_data`, `nos`←old `tos`, `depth`+1.
  - If old depth ≥ 2, spill: `ram_addr`←`sp`, `ram_wdata`←old `nos`, `ram_wen`←1, `sp`+1, go to WR. Otherwise stay in IDLE.
- WR: `ram_wen`←0, go to IDLE.
- POP:
  - If depth = 0, reject: `err_underflow` is set.
  - Otherwise `tos`←`nos`, `depth`−1.
  - If `sp` > 0, refill: `ram_addr`←`sp`−1, `sp`−1, go to RD_WAIT. Otherwise stay in IDLE.
  - The popped value is `tos` as it stood at the accept edge.
- REPLACE2:
  - If depth < 2, reject: `err_underflow` is set.
  - Otherwise `tos`←`cmd_data`, `depth`−1, and refill exactly as POP when `sp` > 0.
- RD_WAIT: go to RD_CAP (the RAM output settles during this cycle).
- RD_CAP: `nos`←`ram_rdata`, go to IDLE.
- SWAP: see Configuration.
- Rejected commands are still consumed (handshake completes) and take one cycle.
- Unused element registers: when depth drops below 2, `nos` holds a don't-care value; when depth is 0, `tos` holds a don't-care value. The bench must not check them in those cases.
- Error flags clear only on `RST`.

## Timing
- Reset values: `cmd_ready`=1, `tos`=0, `nos`=0, `depth`=0, `sp`=0, both error flags=0, `ram_wen`=0, `ram_addr`=0, `ram_wdata`=0. FSM is in IDLE.
- `RST` takes priority over any command in the same cycle.
- `RST` asserted mid-sequence (WR, RD_WAIT or RD_CAP) aborts the sequence. `ram_wen` is 0 after that edge, and RAM contents are left as they are.
- `ram_wen` is registered and high for exactly one cycle per spill. `ram_addr`/`ram_wdata` are stable during that cycle.
- Latency, counted as accept edge to `cmd_ready`=1:
  - PUSH without spill, POP/REPLACE2 without refill, SWAP, rejected commands: 0 extra cycles; back-to-back acceptance is allowed.
  - PUSH with spill: 1 cycle.
  - POP/REPLACE2 with refill: 2 cycles.
- `tos` and `depth` update at the accept edge. `nos` is final at the accept edge, except after a refill, where it is final at the RD_CAP edge.
- Width rules:
  - `sp` never wraps. Full is checked before incrementing, empty before decrementing.
  - `depth` is sized so 2^ADDR_W+2 is representable with no overflow.

## Configuration
- `SCRATCH_STACK_SWAP_EN` defined:
  - op 11 = SWAP: `tos`↔`nos` in one cycle, no RAM access, `depth` unchanged.
  - If depth < 2, reject: `err_underflow` is set.
- Not defined: op 11 is accepted as a no-op. No state changes, no flag is set, and no swap logic is synthesized.

## Test plan
- Reset, then PUSH 0x11, 0x22, 0x33 → `tos`=0x33, `nos`=0x22, `depth`=3. The third push gives one `ram_wen` pulse with `ram_addr`=0, `ram_wdata`=0x11; `cmd_ready` is low for 1 cycle.
- From that state, POP → `tos`=0x22 at the accept edge, `nos`=0x11 two cycles later, `depth`=2, `cmd_ready` low for 2 cycles. POP again → `tos`=0x11, `depth`=1, no RAM access.
- Push 258 values 0..257 → `depth`=258, no error. 259th PUSH 0xDEAD → `err_overflow`=1, `depth` stays 258, `tos`=257.
- Pop all 258 values and check LIFO order 257..0. One further POP → `err_underflow`=1, `depth`=0. REPLACE2 at depth 1 → `err_underflow` is set, `tos` unchanged.
- Stack [1,2,3] (3 on top), REPLACE2 with data 5 → `tos`=5, `nos`=1, `depth`=2. With `SCRATCH_STACK_SWAP_EN`, SWAP → `tos`=1, `nos`=5; without the macro, SWAP leaves `tos`=5, `nos`=1.
- Assert `RST` for one cycle in RD_WAIT of a refill → next cycle `cmd_ready`=1, `depth`=0, `ram_wen`=0, errors cleared.
